// File: rtl/exc_commit_if.sv
// ---------------------------------------------------------------------------
// exc_commit_if
// Bundles every non-clock signal of the exception commit unit.
//   mem side : m_valid, m_pc, m_bd, exception flags, m_eret, m_badvaddr, m_ready
//   cp0 side : int_response, cp0_epc, exc_valid/excode/bd/epc/badvaddr/eret
//   pipeline : flush
//   fetch    : redirect_valid, redirect_pc, redirect_ready
// Modports:
//   slave  - the exc_commit unit itself
//   master - the surrounding pipeline / cp0 / fetch (or a testbench)
// ---------------------------------------------------------------------------
interface exc_commit_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_if_adel;
  logic        m_id_ri;
  logic        m_id_sys;
  logic        m_id_bp;
  logic        m_ex_ov;
  logic        m_mem_adel;
  logic        m_mem_ades;
  logic        m_eret;
  logic [31:0] m_badvaddr;
  logic        int_response;
  logic [31:0] cp0_epc;
  logic        m_ready;

  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;

  logic        flush;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  m_valid, m_pc, m_bd, m_if_adel, m_id_ri, m_id_sys, m_id_bp,
           m_ex_ov, m_mem_adel, m_mem_ades, m_eret, m_badvaddr,
           int_response, cp0_epc, redirect_ready,
    output m_ready, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr,
           exc_eret, flush, redirect_valid, redirect_pc
  );

  modport master (
    output m_valid, m_pc, m_bd, m_if_adel, m_id_ri, m_id_sys, m_id_bp,
           m_ex_ov, m_mem_adel, m_mem_ades, m_eret, m_badvaddr,
           int_response, cp0_epc, redirect_ready,
    input  m_ready, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr,
           exc_eret, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_commit.sv
// ---------------------------------------------------------------------------
// exc_commit
// Exception commit unit at the MEM/WB boundary. Merges the pipeline
// exception flags with the cp0 interrupt request, selects one cause by MIPS
// priority, reports it to cp0 for one cycle, flushes the pipeline and holds
// a PC redirect towards fetch until fetch accepts it.
// Ports:
//   clk    - clock
//   resetn - asynchronous active-low reset
//   bus    - exc_commit_if.slave (mem, cp0, flush and fetch redirect signals)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | commit normally; an exception/interrupt/eret fires here
// S_REDIR | redirect to fetch pending; flush asserted, commits ignored
// ---------------------------------------------------------------------------
module exc_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic          clk,
  input  logic          resetn,
  exc_commit_if.slave   bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_REDIR = 1'b1
  } state_t;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_redirect_valid;
  logic        w_redirect_valid_nxt;
  logic [31:0] r_redirect_pc;
  logic [31:0] w_redirect_pc_nxt;

  logic        w_any_flag;
  logic        w_cause;
  logic        w_take;
  logic        w_sel_eret;
  logic [4:0]  w_excode;
  logic [31:0] w_epc;
  logic [31:0] w_badvaddr;

  assign w_any_flag = bus.m_if_adel | bus.m_id_ri | bus.m_id_sys | bus.m_id_bp |
                      bus.m_ex_ov | bus.m_mem_adel | bus.m_mem_ades;
  assign w_cause    = bus.int_response | w_any_flag | bus.m_eret;

  // eret only wins when nothing else is pending on the same instruction
  assign w_sel_eret = bus.m_eret & ~bus.int_response & ~w_any_flag;

  // An EPC for a delay-slot instruction points back at the branch.
  assign w_epc      = bus.m_bd ? (bus.m_pc - 32'd4) : bus.m_pc;

  // A fetch address error faults on the PC itself, not a data address.
  assign w_badvaddr = bus.m_if_adel ? bus.m_pc : bus.m_badvaddr;

  always_comb begin
    w_excode = EXC_INT;
    if (bus.int_response)    w_excode = EXC_INT;
    else if (bus.m_if_adel)  w_excode = EXC_ADEL;
    else if (bus.m_id_ri)    w_excode = EXC_RI;
    else if (bus.m_id_sys)   w_excode = EXC_SYS;
    else if (bus.m_id_bp)    w_excode = EXC_BP;
    else if (bus.m_ex_ov)    w_excode = EXC_OV;
    else if (bus.m_mem_adel) w_excode = EXC_ADEL;
    else if (bus.m_mem_ades) w_excode = EXC_ADES;
    else                     w_excode = EXC_INT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= S_IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
    end else begin
      r_state          <= w_state_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_redirect_valid_nxt = r_redirect_valid;
    w_redirect_pc_nxt    = r_redirect_pc;
    w_take               = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_take = bus.m_valid & w_cause;
        if (w_take) begin
          w_state_nxt          = S_REDIR;
          w_redirect_valid_nxt = 1'b1;
          w_redirect_pc_nxt    = w_sel_eret ? bus.cp0_epc : EXC_VECTOR;
        end
      end
      S_REDIR: begin
        if (bus.redirect_ready) begin
          w_state_nxt          = S_IDLE;
          w_redirect_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt          = S_IDLE;
        w_redirect_valid_nxt = 1'b0;
      end
    endcase
  end

  // MEM is never stalled: in S_REDIR wrong-path commits are accepted and
  // discarded by the flush rather than held back.
  assign bus.m_ready        = 1'b1;

  assign bus.exc_valid      = w_take;
  assign bus.exc_excode     = (w_take & ~w_sel_eret) ? w_excode : 5'd0;
  assign bus.exc_bd         = w_take & bus.m_bd;
  assign bus.exc_epc        = w_take ? w_epc : 32'd0;
  assign bus.exc_badvaddr   = w_take ? w_badvaddr : 32'd0;
  assign bus.exc_eret       = w_take & w_sel_eret;

  assign bus.flush          = w_take | (r_state == S_REDIR);

  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_exc_commit.sv
module tb_exc_commit;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk;
  logic resetn;

  exc_commit_if u_if ();

  exc_commit #(.EXC_VECTOR(VEC)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        chk_bad;
    logic        eret;
  } exp_t;

  exp_t        q_exc[$];
  logic [31:0] q_redir[$];

  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (u_if.exc_valid) begin
        if (q_exc.size() == 0) begin
          check("spurious_exc_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q_exc.pop_front();
          check("excode", {27'd0, u_if.exc_excode}, {27'd0, e.code});
          check("exc_bd", {31'd0, u_if.exc_bd}, {31'd0, e.bd});
          check("exc_epc", u_if.exc_epc, e.epc);
          check("exc_eret", {31'd0, u_if.exc_eret}, {31'd0, e.eret});
          if (e.chk_bad) check("exc_badvaddr", u_if.exc_badvaddr, e.bad);
        end
      end
      if (u_if.redirect_valid && u_if.redirect_ready) begin
        if (q_redir.size() == 0) check("spurious_redirect", 32'd1, 32'd0);
        else check("redirect_pc", u_if.redirect_pc, q_redir.pop_front());
      end
    end
  end

  task automatic clear_mem;
    u_if.m_valid      = 1'b0;
    u_if.m_pc         = 32'd0;
    u_if.m_bd         = 1'b0;
    u_if.m_if_adel    = 1'b0;
    u_if.m_id_ri      = 1'b0;
    u_if.m_id_sys     = 1'b0;
    u_if.m_id_bp      = 1'b0;
    u_if.m_ex_ov      = 1'b0;
    u_if.m_mem_adel   = 1'b0;
    u_if.m_mem_ades   = 1'b0;
    u_if.m_eret       = 1'b0;
    u_if.m_badvaddr   = 32'd0;
    u_if.int_response = 1'b0;
  endtask

  // flags = {if_adel, ri, sys, bp, ov, mem_adel, mem_ades}
  task automatic drive(input logic [31:0] pc, input logic bd, input logic [6:0] flags,
                       input logic eret, input logic intr, input logic [31:0] badv);
    u_if.m_valid      = 1'b1;
    u_if.m_pc         = pc;
    u_if.m_bd         = bd;
    u_if.m_if_adel    = flags[6];
    u_if.m_id_ri      = flags[5];
    u_if.m_id_sys     = flags[4];
    u_if.m_id_bp      = flags[3];
    u_if.m_ex_ov      = flags[2];
    u_if.m_mem_adel   = flags[1];
    u_if.m_mem_ades   = flags[0];
    u_if.m_eret       = eret;
    u_if.int_response = intr;
    u_if.m_badvaddr   = badv;
  endtask

  // One excepting instruction, then hold the redirect for `delay` cycles
  // with ready low while junk (a valid syscall + interrupt) is presented.
  task automatic run_vec(input string tag, input logic [31:0] pc, input logic bd,
                         input logic [6:0] flags, input logic eret, input logic intr,
                         input logic [31:0] badv, input logic [31:0] epc_in, input int delay,
                         input logic [4:0] x_code, input logic [31:0] x_epc,
                         input logic [31:0] x_bad, input logic x_chk_bad,
                         input logic x_eret, input logic [31:0] x_redir);
    exp_t e;
    @(posedge clk); #1;
    drive(pc, bd, flags, eret, intr, badv);
    u_if.cp0_epc        = epc_in;
    u_if.redirect_ready = (delay == 0);
    e.code = x_code; e.bd = bd; e.epc = x_epc; e.bad = x_bad;
    e.chk_bad = x_chk_bad; e.eret = x_eret;
    q_exc.push_back(e);
    q_redir.push_back(x_redir);
    @(negedge clk);
    check({tag, "_take_flush"}, {31'd0, u_if.flush}, 32'd1);
    check({tag, "_take_valid"}, {31'd0, u_if.exc_valid}, 32'd1);
    check({tag, "_m_ready"}, {31'd0, u_if.m_ready}, 32'd1);
    @(posedge clk); #1;
    clear_mem();
    if (delay > 0) begin
      drive(32'h80009000, 1'b0, 7'b0010000, 1'b0, 1'b1, 32'd0);
      u_if.cp0_epc = 32'hDEADBEEF;
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({tag, "_hold_rv"}, {31'd0, u_if.redirect_valid}, 32'd1);
      check({tag, "_hold_pc"}, u_if.redirect_pc, x_redir);
      check({tag, "_hold_flush"}, {31'd0, u_if.flush}, 32'd1);
      check({tag, "_hold_excv"}, {31'd0, u_if.exc_valid}, 32'd0);
      @(posedge clk); #1;
    end
    clear_mem();
    u_if.redirect_ready = 1'b1;
    @(negedge clk);
    check({tag, "_redir_valid"}, {31'd0, u_if.redirect_valid}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_post_rv"}, {31'd0, u_if.redirect_valid}, 32'd0);
    check({tag, "_post_flush"}, {31'd0, u_if.flush}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    clear_mem();
    u_if.cp0_epc        = 32'd0;
    u_if.redirect_ready = 1'b1;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rv", {31'd0, u_if.redirect_valid}, 32'd0);
    check("rst_rpc", u_if.redirect_pc, 32'd0);
    check("rst_excv", {31'd0, u_if.exc_valid}, 32'd0);
    check("rst_flush", {31'd0, u_if.flush}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // redirect_ready while idle is ignored
    repeat (2) @(negedge clk);
    check("idle_ready_rv", {31'd0, u_if.redirect_valid}, 32'd0);

    run_vec("sys", 32'h80001000, 1'b0, 7'b0010000, 1'b0, 1'b0, 32'd0, 32'd0, 0,
            5'd8, 32'h80001000, 32'd0, 1'b0, 1'b0, VEC);
    run_vec("ri_ov", 32'h80000008, 1'b1, 7'b0100100, 1'b0, 1'b0, 32'd0, 32'd0, 0,
            5'd10, 32'h80000004, 32'd0, 1'b0, 1'b0, VEC);
    run_vec("ifadel", 32'h00000003, 1'b0, 7'b1000001, 1'b0, 1'b0, 32'h12345678, 32'd0, 0,
            5'd4, 32'h00000003, 32'h00000003, 1'b1, 1'b0, VEC);
    run_vec("ades", 32'h80000100, 1'b0, 7'b0000001, 1'b0, 1'b0, 32'h80000002, 32'd0, 0,
            5'd5, 32'h80000100, 32'h80000002, 1'b1, 1'b0, VEC);
    run_vec("eret", 32'h80000200, 1'b0, 7'b0000000, 1'b1, 1'b0, 32'd0, 32'h80002000, 3,
            5'd0, 32'h80000200, 32'd0, 1'b0, 1'b1, 32'h80002000);
    run_vec("bp_bd", 32'h80000010, 1'b1, 7'b0001000, 1'b0, 1'b0, 32'd0, 32'd0, 1,
            5'd9, 32'h8000000C, 32'd0, 1'b0, 1'b0, VEC);
    run_vec("ldadel", 32'h80000300, 1'b0, 7'b0000011, 1'b0, 1'b0, 32'h80000041, 32'd0, 0,
            5'd4, 32'h80000300, 32'h80000041, 1'b1, 1'b0, VEC);
    run_vec("int_over", 32'h80000020, 1'b0, 7'b0010000, 1'b1, 1'b1, 32'd0, 32'h80005000, 0,
            5'd0, 32'h80000020, 32'd0, 1'b0, 1'b0, VEC);
    run_vec("ov_eret", 32'h80000024, 1'b0, 7'b0000100, 1'b1, 1'b0, 32'd0, 32'h80006000, 0,
            5'd12, 32'h80000024, 32'd0, 1'b0, 1'b0, VEC);
    run_vec("bd_wrap", 32'h00000000, 1'b1, 7'b0010000, 1'b0, 1'b0, 32'd0, 32'd0, 0,
            5'd8, 32'hFFFFFFFC, 32'd0, 1'b0, 1'b0, VEC);

    // interrupt pending with no valid instruction: nothing fires
    @(posedge clk); #1;
    u_if.int_response = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("int_wait_excv", {31'd0, u_if.exc_valid}, 32'd0);
      check("int_wait_flush", {31'd0, u_if.flush}, 32'd0);
      @(posedge clk); #1;
    end
    begin
      exp_t e;
      drive(32'h80003000, 1'b0, 7'b0000000, 1'b0, 1'b1, 32'd0);
      u_if.redirect_ready = 1'b0;
      e.code = 5'd0; e.bd = 1'b0; e.epc = 32'h80003000; e.bad = 32'd0;
      e.chk_bad = 1'b0; e.eret = 1'b0;
      q_exc.push_back(e);
      q_redir.push_back(VEC);
    end
    @(posedge clk); #1;
    clear_mem();
    @(negedge clk);
    check("int_redir_rv", {31'd0, u_if.redirect_valid}, 32'd1);
    check("int_redir_pc", u_if.redirect_pc, VEC);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_rv", {31'd0, u_if.redirect_valid}, 32'd0);
    check("abort_rpc", u_if.redirect_pc, 32'd0);
    check("abort_flush", {31'd0, u_if.flush}, 32'd0);
    if (q_redir.size() > 0) void'(q_redir.pop_front());
    @(posedge clk); #1;
    resetn = 1'b1;

    run_vec("recover", 32'h80004000, 1'b0, 7'b0010000, 1'b0, 1'b0, 32'd0, 32'd0, 0,
            5'd8, 32'h80004000, 32'd0, 1'b0, 1'b0, VEC);

    repeat (2) @(posedge clk);
    check("q_exc_empty", q_exc.size(), 32'd0);
    check("q_redir_empty", q_redir.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
